// File: rtl/osd_pkg.sv
// Shared widths and cell geometry for the OSD text engine.
// Imported by the renderer top and its row shifter.
package osd_pkg;

    localparam int CELL_W      = 8;
    localparam int BPP         = 4;
    localparam int FONT_ADDR_W = 11;
    localparam int FONT_DATA_W = 32;
    localparam int CHAR_ADDR_W = 11;
    localparam int X_W         = 12;
    localparam int Y_W         = 12;

endpackage

// File: rtl/osd_row_shifter.sv
// Font row pipeline: prefetch buffer, pixel shifter and registered
// palette index output.
module osd_row_shifter
    import osd_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ce,
    input  logic                   de,
    input  logic                   load,
    input  logic                   cap,
    input  logic                   win,
    input  logic [FONT_DATA_W-1:0] font_data,
    output logic [BPP-1:0]         pal_idx
);

    logic [FONT_DATA_W-1:0] next_row_q, next_row_d;
    logic [FONT_DATA_W-1:0] shifter_q, shifter_d;
    logic [BPP-1:0]         pal_q, pal_d;

    always_comb begin
        next_row_d = next_row_q;
        shifter_d  = shifter_q;
        pal_d      = pal_q;
        // ROM capture completes even when the pixel enable is low
        if (cap) next_row_d = font_data;
        if (ce) begin
            pal_d = win ? shifter_q[FONT_DATA_W-1 -: BPP] : '0;
            if (!de)       shifter_d = '0;
            else if (load) shifter_d = next_row_q;
            else           shifter_d = shifter_q << BPP;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            next_row_q <= '0;
            shifter_q  <= '0;
            pal_q      <= '0;
        end else begin
            next_row_q <= next_row_d;
            shifter_q  <= shifter_d;
            pal_q      <= pal_d;
        end
    end

    assign pal_idx = pal_q;

endmodule

// File: rtl/osd_char_renderer.sv
// Raster-driven OSD text engine: tracks position, fetches char codes
// and font rows one cell ahead, and emits a 4bpp palette index per pixel.
module osd_char_renderer
    import osd_pkg::*;
#(
    parameter int OSD_X = 64,
    parameter int OSD_Y = 32,
    parameter int COLS  = 32,
    parameter int ROWS  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   pix_ce,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    input  logic                   osd_en,
    output logic [CHAR_ADDR_W-1:0] char_addr,
    input  logic [7:0]             char_code,
    output logic [FONT_ADDR_W-1:0] font_addr,
    input  logic [FONT_DATA_W-1:0] font_data,
    output logic [BPP-1:0]         pal_idx,
    output logic                   osd_px,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o
);

    localparam logic [X_W-1:0] WIN_X0   = X_W'(OSD_X);
    localparam logic [X_W-1:0] WIN_X1   = X_W'(OSD_X + COLS * CELL_W);
    localparam logic [X_W-1:0] FETCH_X0 = X_W'(OSD_X - CELL_W);
    localparam logic [X_W-1:0] COLS_X   = X_W'(COLS);
    localparam logic [Y_W-1:0] WIN_Y0   = Y_W'(OSD_Y);
    localparam logic [Y_W-1:0] WIN_Y1   = Y_W'(OSD_Y + ROWS * CELL_W);
    localparam logic [CHAR_ADDR_W-1:0] COLS_A = CHAR_ADDR_W'(COLS);

    logic [X_W-1:0]         x_q, x_d;
    logic [Y_W-1:0]         y_q, y_d;
    logic                   de_p_q, de_p_d;
    logic                   vs_p_q, vs_p_d;
    logic                   osd_en_q, osd_en_d;
    logic [CHAR_ADDR_W-1:0] row_base_q, row_base_d;
    logic [CHAR_ADDR_W-1:0] char_addr_q, char_addr_d;
    logic [FONT_ADDR_W-1:0] font_addr_q, font_addr_d;
    logic [3:0]             fetch_q, fetch_d;
    logic [2:0]             sync1_q, sync_q;

    logic           vs_rise, de_fall;
    logic [X_W-1:0] x_cur, fx;
    logic [2:0]     ly_lo;
    logic           line_win, px_win, fetch_go, load;

    always_comb begin
        vs_rise  = pix_ce && vs_i && !vs_p_q;
        de_fall  = pix_ce && !de_i && de_p_q;
        x_cur    = (de_i && !de_p_q) ? '0 : x_q;
        fx       = x_cur - FETCH_X0;
        ly_lo    = y_q[2:0] - WIN_Y0[2:0];
        line_win = (y_q >= WIN_Y0) && (y_q < WIN_Y1);
        px_win   = de_i && line_win && osd_en_q
                && (x_cur >= WIN_X0) && (x_cur < WIN_X1);
        fetch_go = pix_ce && de_i && line_win && (x_cur >= FETCH_X0)
                && (fx[2:0] == 3'd0) && ((fx >> 3) < COLS_X);
        load     = (fx[2:0] == 3'd7);

        x_d         = x_q;
        y_d         = y_q;
        de_p_d      = pix_ce ? de_i : de_p_q;
        vs_p_d      = pix_ce ? vs_i : vs_p_q;
        osd_en_d    = vs_rise ? osd_en : osd_en_q;
        row_base_d  = row_base_q;
        char_addr_d = char_addr_q;
        font_addr_d = font_addr_q;
        fetch_d     = {fetch_q[2:0], fetch_go};

        if (pix_ce && de_i) x_d = x_cur + 1'b1;
        if (vs_rise)      y_d = '0;
        else if (de_fall) y_d = y_q + 1'b1;

        // Advance one text row after the last line of each cell row
        if (vs_rise)
            row_base_d = '0;
        else if (de_fall && line_win && ly_lo == 3'd7)
            row_base_d = row_base_q + COLS_A;

        if (fetch_go)
            char_addr_d = row_base_q + CHAR_ADDR_W'(fx >> 3);
        if (fetch_q[1])
            font_addr_d = {char_code, ly_lo};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q         <= '0;
            y_q         <= '0;
            de_p_q      <= 1'b0;
            vs_p_q      <= 1'b0;
            osd_en_q    <= 1'b0;
            row_base_q  <= '0;
            char_addr_q <= '0;
            font_addr_q <= '0;
            fetch_q     <= '0;
            sync1_q     <= '0;
            sync_q      <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            de_p_q      <= de_p_d;
            vs_p_q      <= vs_p_d;
            osd_en_q    <= osd_en_d;
            row_base_q  <= row_base_d;
            char_addr_q <= char_addr_d;
            font_addr_q <= font_addr_d;
            fetch_q     <= fetch_d;
            sync1_q     <= {de_i, hs_i, vs_i};
            sync_q      <= sync1_q;
        end
    end

    osd_row_shifter u_shift (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (pix_ce),
        .de        (de_i),
        .load      (load),
        .cap       (fetch_q[3]),
        .win       (px_win),
        .font_data (font_data),
        .pal_idx   (pal_idx)
    );

    assign char_addr = char_addr_q;
    assign font_addr = font_addr_q;
    assign osd_px    = |pal_idx;
    assign de_o      = sync_q[2];
    assign hs_o      = sync_q[1];
    assign vs_o      = sync_q[0];

endmodule

// File: tb/tb_osd_char_renderer.sv
// Directed bench for osd_char_renderer with char buffer and font ROM
// models; pixels are recorded per line and compared against hand values.
module tb_osd_char_renderer;

    logic        clk = 1'b0;
    logic        reset_n, pix_ce, de_i, hs_i, vs_i, osd_en;
    logic [10:0] char_addr, font_addr;
    logic [7:0]  char_code;
    logic [31:0] font_data;
    logic [3:0]  pal_idx;
    logic        osd_px, de_o, hs_o, vs_o;

    always #5 clk = ~clk;

    osd_char_renderer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pix_ce    (pix_ce),
        .de_i      (de_i),
        .hs_i      (hs_i),
        .vs_i      (vs_i),
        .osd_en    (osd_en),
        .char_addr (char_addr),
        .char_code (char_code),
        .font_addr (font_addr),
        .font_data (font_data),
        .pal_idx   (pal_idx),
        .osd_px    (osd_px),
        .de_o      (de_o),
        .hs_o      (hs_o),
        .vs_o      (vs_o)
    );

    logic [7:0]  char_mem [0:2047];
    logic [31:0] font_mem [0:2047];

    always @(posedge clk) begin
        char_code <= char_mem[char_addr];
        font_data <= font_mem[font_addr];
    end

    logic       seen_clr;
    logic       seen_ca;
    logic [7:0] seen_fa;

    always @(posedge clk) begin
        if (seen_clr) begin
            seen_ca <= 1'b0;
            seen_fa <= 8'h00;
        end else begin
            if (char_addr == 11'd101) seen_ca <= 1'b1;
            if (font_addr[10:3] == 8'h7E) seen_fa[font_addr[2:0]] <= 1'b1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int sync_err, hold_err;
    bit sync_chk;
    logic [2:0] prev_in;
    logic [3:0] cap_pal [0:335];
    logic       cap_px  [0:335];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic de, input logic hs, input logic vs,
                        input logic ce);
        de_i   = de;
        hs_i   = hs;
        vs_i   = vs;
        pix_ce = ce;
        @(posedge clk);
        #1;
        if (sync_chk && {de_o, hs_o, vs_o} !== prev_in) sync_err++;
        prev_in = {de, hs, vs};
    endtask

    task automatic run_line(input int len, input bit ce2);
        for (int x = 0; x < len; x++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            cap_pal[x] = pal_idx;
            cap_px[x]  = osd_px;
            if (ce2) begin
                step(1'b1, 1'b0, 1'b0, 1'b0);
                if (pal_idx !== cap_pal[x]) hold_err++;
            end
        end
        for (int b = 0; b < 8; b++) begin
            step(1'b0, (b >= 2 && b < 6), 1'b0, 1'b1);
            cap_pal[len + b] = pal_idx;
            cap_px[len + b]  = osd_px;
        end
    endtask

    task automatic short_lines(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic vsync();
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_line(input string tag, input logic [31:0] row);
        int err;
        logic [31:0] r;
        err = 0;
        for (int x = 64; x < 320; x++) begin
            r = row << (4 * ((x - 64) % 8));
            if (cap_pal[x] !== r[31:28]) err++;
            if (cap_px[x] !== (r[31:28] != 4'h0)) err++;
        end
        check(tag, 32'(err), 32'd0);
    endtask

    function automatic int nz_line();
        int n;
        n = 0;
        for (int x = 0; x < 336; x++)
            if (cap_pal[x] != 4'h0 || cap_px[x] != 1'b0) n++;
        return n;
    endfunction

    initial begin
        int err;
        logic [31:0] f7e;
        for (int i = 0; i < 2048; i++) begin
            char_mem[i] = 8'h41;
            font_mem[i] = 32'h12345678;
        end
        char_mem[101] = 8'h7E;
        for (int l = 0; l < 8; l++)
            font_mem[{8'h7E, 3'(l)}] = 32'hFEDCBA90 | 32'(l);
        char_code = 8'h00;
        font_data = 32'h0;
        seen_clr  = 1'b1;
        sync_chk  = 1'b0;
        sync_err  = 0;
        hold_err  = 0;
        prev_in   = 3'b000;
        reset_n   = 1'b0;
        osd_en    = 1'b0;
        pix_ce    = 1'b0;
        de_i      = 1'b0;
        hs_i      = 1'b0;
        vs_i      = 1'b0;

        // Reset held with random timing
        err = 0;
        for (int i = 0; i < 40; i++) begin
            de_i   = 1'($urandom_range(0, 1));
            hs_i   = 1'($urandom_range(0, 1));
            vs_i   = 1'($urandom_range(0, 1));
            pix_ce = 1'($urandom_range(0, 1));
            osd_en = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if ({pal_idx, osd_px, de_o, hs_o, vs_o} != 8'h00) err++;
            if (char_addr != 11'd0 || font_addr != 11'd0) err++;
        end
        check("reset_outs", 32'(err), 32'd0);
        de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        osd_en  = 1'b1;
        reset_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        short_lines(32);
        run_line(328, 1'b0);
        check("pre_vs_zero", 32'(nz_line()), 32'd0);

        // All 0x41 / 0x12345678, line 32
        vsync();
        seen_clr = 1'b0;
        short_lines(32);
        run_line(328, 1'b0);
        check_line("t2_pattern", 32'h12345678);
        check("t2_x63", 32'(cap_pal[63]), 32'h0);
        check("t2_x320", 32'(cap_pal[320]), 32'h0);
        check("t2_x64", 32'(cap_pal[64]), 32'h1);
        check("t2_x71", 32'(cap_pal[71]), 32'h8);
        check("t2_px63", 32'(cap_px[63]), 32'h0);
        check("t2_px319", 32'(cap_px[319]), 32'h1);

        // de drops mid-cell on line 33, line 34 renders cleanly
        run_line(100, 1'b0);
        check("abort_x99", 32'(cap_pal[99]), 32'h4);
        check("abort_blank", 32'(cap_pal[100]), 32'h0);
        run_line(328, 1'b0);
        check_line("after_abort", 32'h12345678);

        // Cell (3,5) = 0x7E on lines 56..63
        short_lines(21);
        for (int l = 0; l < 8; l++) begin
            run_line(328, 1'b0);
            f7e = 32'hFEDCBA90 | 32'(l);
            check($sformatf("c35_first_l%0d", l), 32'(cap_pal[104]), 32'hF);
            check($sformatf("c35_last_l%0d", l), 32'(cap_pal[111]),
                  32'(f7e[3:0]));
            check($sformatf("c34_last_l%0d", l), 32'(cap_pal[103]), 32'h8);
            check($sformatf("c36_first_l%0d", l), 32'(cap_pal[112]), 32'h1);
        end
        check("char_addr_101", 32'(seen_ca), 32'h1);
        check("font_addr_7e", 32'(seen_fa), 32'hFF);

        // pix_ce every 2nd clk
        vsync();
        short_lines(32);
        hold_err = 0;
        run_line(328, 1'b1);
        check_line("ce2_pattern", 32'h12345678);
        check("ce2_hold", 32'(hold_err), 32'd0);
        check("ce2_x63", 32'(cap_pal[63]), 32'h0);
        check("ce2_x320", 32'(cap_pal[320]), 32'h0);

        // osd_en dropped mid-frame
        vsync();
        osd_en = 1'b0;
        short_lines(100);
        run_line(328, 1'b0);
        check_line("en_drop_l100", 32'h12345678);
        short_lines(58);
        run_line(328, 1'b0);
        check("last_win_l159", 32'(cap_pal[64]), 32'h1);
        run_line(328, 1'b0);
        check("below_win_l160", 32'(nz_line()), 32'd0);
        vsync();
        short_lines(32);
        run_line(328, 1'b0);
        check("next_frame_off", 32'(nz_line()), 32'd0);

        // Alternating font row and sync delay
        for (int l = 0; l < 8; l++) font_mem[{8'h41, 3'(l)}] = 32'h0F0F0F0F;
        osd_en = 1'b1;
        vsync();
        short_lines(32);
        sync_err = 0;
        sync_chk = 1'b1;
        run_line(328, 1'b0);
        sync_chk = 1'b0;
        check_line("toggle_pattern", 32'h0F0F0F0F);
        check("toggle_px64", 32'(cap_px[64]), 32'h0);
        check("toggle_px65", 32'(cap_px[65]), 32'h1);
        check("sync_delay", 32'(sync_err), 32'd0);

        // Reset asserted mid-line
        for (int x = 0; x < 100; x++) step(1'b1, 1'b0, 1'b0, 1'b1);
        check("pre_reset_x99", 32'(pal_idx), 32'hF);
        reset_n = 1'b0;
        #1;
        check("async_reset_pal", 32'(pal_idx), 32'h0);
        check("async_reset_px", 32'(osd_px), 32'h0);
        #3;
        reset_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        short_lines(32);
        run_line(328, 1'b0);
        check("restart_wait", 32'(nz_line()), 32'd0);
        vsync();
        short_lines(32);
        run_line(328, 1'b0);
        check_line("restart_after_vs", 32'h0F0F0F0F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
